io_clock_gen: RTL and testbench



---
 rtl/io_clock_pkg.sv | 12 +
 rtl/div_load_reg.sv | 29 ++
 rtl/io_clock_gen.sv | 109 ++++++++++
 tb/tb_io_clock_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/io_clock_pkg.sv
// Shared types and defaults for the io_clock divider.
package io_clock_pkg;

    localparam int DIV_WIDTH_DEF = 8;
    localparam int RESET_DIV_DEF = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clk_state_t;

endpackage

// File: rtl/div_load_reg.sv
// Pending divisor holder: a set strobe captures a new value, clear retires it.
import io_clock_pkg::*;

module div_load_reg #(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 core_clock,
    input  logic                 rst_n,
    input  logic                 set,
    input  logic [DIV_WIDTH-1:0] set_value,
    input  logic                 clear,
    output logic [DIV_WIDTH-1:0] pend_div,
    output logic                 pend_flag
);

    // A set on the same edge as a clear wins: that load is kept for the next boundary.
    always_ff @(posedge core_clock or negedge rst_n) begin
        if (!rst_n) begin
            pend_div  <= '0;
            pend_flag <= 1'b0;
        end else if (set) begin
            pend_div  <= set_value;
            pend_flag <= 1'b1;
        end else if (clear) begin
            pend_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/io_clock_gen.sv
// Glitch-free programmable divider producing io_clock from core_clock.
//   state | meaning
//   IDLE  | output parked low, pending divisor applied immediately
//   RUN   | output toggling; enable/pending divisor sampled at period boundary
import io_clock_pkg::*;

module io_clock_gen #(
    parameter int          DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned RESET_DIV = RESET_DIV_DEF
) (
    input  logic                 core_clock,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 clock_out,
    output logic                 clock_valid
);

    clk_state_t           state, state_nxt;
    logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
    logic [DIV_WIDTH-1:0] active_div, active_nxt;
    logic [DIV_WIDTH-1:0] pend_div;
    logic                 pend_flag;
    logic                 apply;
    logic                 clock_out_nxt, clock_valid_nxt, div_ack_nxt;

    div_load_reg #(.DIV_WIDTH(DIV_WIDTH)) u_div_load_reg (
        .core_clock (core_clock),
        .rst_n      (rst_n),
        .set        (div_load),
        .set_value  (div_value),
        .clear      (apply),
        .pend_div   (pend_div),
        .pend_flag  (pend_flag)
    );

    always_ff @(posedge core_clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            active_div  <= DIV_WIDTH'(RESET_DIV);
            clock_out   <= 1'b0;
            clock_valid <= 1'b0;
            div_ack     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            active_div  <= active_nxt;
            clock_out   <= clock_out_nxt;
            clock_valid <= clock_valid_nxt;
            div_ack     <= div_ack_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        active_nxt      = active_div;
        clock_out_nxt   = clock_out;
        clock_valid_nxt = clock_valid;
        div_ack_nxt     = 1'b0;
        apply           = 1'b0;

        case (state)
            IDLE: begin
                clock_out_nxt   = 1'b0;
                clock_valid_nxt = 1'b0;
                cnt_nxt         = '0;
                if (pend_flag) begin
                    apply       = 1'b1;
                    active_nxt  = pend_div;
                    div_ack_nxt = 1'b1;
                end
                if (enable) begin
                    state_nxt       = RUN;
                    clock_out_nxt   = 1'b1;
                    clock_valid_nxt = 1'b1;
                end
            end
            RUN: begin
                if (cnt != active_div) begin
                    cnt_nxt = cnt + DIV_WIDTH'(1);
                end else if (clock_out) begin
                    clock_out_nxt = 1'b0;
                    cnt_nxt       = '0;
                end else if (!enable) begin
                    // Period boundary with enable dropped: park low.
                    state_nxt       = IDLE;
                    clock_valid_nxt = 1'b0;
                    cnt_nxt         = '0;
                end else begin
                    clock_out_nxt = 1'b1;
                    cnt_nxt       = '0;
                    if (pend_flag) begin
                        apply       = 1'b1;
                        active_nxt  = pend_div;
                        div_ack_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_io_clock_gen.sv
// Directed bench for io_clock_gen: vector table plus multi-cycle sequences.
module tb_io_clock_gen;

    logic       core_clock = 1'b0;
    logic       rst_n      = 1'b0;
    logic       enable     = 1'b0;
    logic [7:0] div_value  = '0;
    logic       div_load   = 1'b0;
    logic       div_ack;
    logic       clock_out;
    logic       clock_valid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] dv;
        logic [2:0] exp; // {clock_out, clock_valid, div_ack}
    } vec_t;

    vec_t vecs[20];

    io_clock_gen #(.DIV_WIDTH(8), .RESET_DIV(1)) dut (
        .core_clock  (core_clock),
        .rst_n       (rst_n),
        .enable      (enable),
        .div_value   (div_value),
        .div_load    (div_load),
        .div_ack     (div_ack),
        .clock_out   (clock_out),
        .clock_valid (clock_valid)
    );

    always #5 core_clock = ~core_clock;

    task automatic check(input string name, input int idx, input logic [2:0] exp);
        logic [2:0] got;
        got = {clock_out, clock_valid, div_ack};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: co/cv/ack got %b required %b", name, idx, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic ld, input logic [7:0] dv,
                        input logic [2:0] exp, input string name, input int idx);
        @(negedge core_clock);
        enable    = en;
        div_load  = ld;
        div_value = dv;
        @(posedge core_clock);
        #1;
        check(name, idx, exp);
    endtask

    task automatic do_reset();
        @(negedge core_clock);
        rst_n    = 1'b0;
        enable   = 1'b0;
        div_load = 1'b0;
        repeat (2) @(negedge core_clock);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'd0, 3'b110};
        vecs[1]  = '{1'b1, 1'b0, 8'd0, 3'b110};
        vecs[2]  = '{1'b1, 1'b0, 8'd0, 3'b010};
        vecs[3]  = '{1'b1, 1'b0, 8'd0, 3'b010};
        vecs[4]  = '{1'b1, 1'b0, 8'd0, 3'b110};
        vecs[5]  = '{1'b1, 1'b0, 8'd0, 3'b110};
        vecs[6]  = '{1'b1, 1'b0, 8'd0, 3'b010};
        vecs[7]  = '{1'b1, 1'b0, 8'd0, 3'b010};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 3'b000};
        vecs[9]  = '{1'b0, 1'b1, 8'd3, 3'b000};
        vecs[10] = '{1'b0, 1'b0, 8'd3, 3'b001};
        vecs[11] = '{1'b1, 1'b0, 8'd3, 3'b110};
        vecs[12] = '{1'b1, 1'b0, 8'd7, 3'b110};
        vecs[13] = '{1'b1, 1'b0, 8'd7, 3'b110};
        vecs[14] = '{1'b1, 1'b0, 8'd7, 3'b110};
        vecs[15] = '{1'b1, 1'b0, 8'd7, 3'b010};
        vecs[16] = '{1'b1, 1'b0, 8'd7, 3'b010};
        vecs[17] = '{1'b1, 1'b0, 8'd7, 3'b010};
        vecs[18] = '{1'b1, 1'b0, 8'd7, 3'b010};
        vecs[19] = '{1'b1, 1'b0, 8'd7, 3'b110};

        // Reset values
        #2;
        check("reset", 0, 3'b000);
        do_reset();
        check("reset_rel", 0, 3'b000);

        // Default divisor, stop, IDLE load of 3, run at period 8
        foreach (vecs[i])
            step(vecs[i].en, vecs[i].ld, vecs[i].dv, vecs[i].exp, "table", i);

        // Load 0 mid-high at div=1: period completes, ack on rising edge, period 2
        do_reset();
        step(1'b1, 1'b0, 8'd0, 3'b110, "ld_run", 0);
        step(1'b1, 1'b1, 8'd0, 3'b110, "ld_run", 1);
        step(1'b1, 1'b0, 8'd0, 3'b010, "ld_run", 2);
        step(1'b1, 1'b0, 8'd0, 3'b010, "ld_run", 3);
        step(1'b1, 1'b0, 8'd0, 3'b111, "ld_run", 4);
        step(1'b1, 1'b0, 8'd0, 3'b010, "ld_run", 5);
        step(1'b1, 1'b0, 8'd0, 3'b110, "ld_run", 6);
        step(1'b1, 1'b0, 8'd0, 3'b010, "ld_run", 7);

        // Two loads in one period at div=2, then a load on a boundary edge
        do_reset();
        step(1'b0, 1'b1, 8'd2, 3'b000, "two_ld", 0);
        step(1'b0, 1'b0, 8'd2, 3'b001, "two_ld", 1);
        step(1'b1, 1'b0, 8'd2, 3'b110, "two_ld", 2);
        step(1'b1, 1'b1, 8'd5, 3'b110, "two_ld", 3);
        step(1'b1, 1'b1, 8'd0, 3'b110, "two_ld", 4);
        step(1'b1, 1'b0, 8'd9, 3'b010, "two_ld", 5);
        step(1'b1, 1'b0, 8'd9, 3'b010, "two_ld", 6);
        step(1'b1, 1'b0, 8'd9, 3'b010, "two_ld", 7);
        step(1'b1, 1'b0, 8'd9, 3'b111, "two_ld", 8);
        step(1'b1, 1'b0, 8'd9, 3'b010, "two_ld", 9);
        step(1'b1, 1'b1, 8'd1, 3'b110, "bnd_ld", 0);
        step(1'b1, 1'b0, 8'd1, 3'b010, "bnd_ld", 1);
        step(1'b1, 1'b0, 8'd1, 3'b111, "bnd_ld", 2);
        step(1'b1, 1'b0, 8'd1, 3'b110, "bnd_ld", 3);
        step(1'b1, 1'b0, 8'd1, 3'b010, "bnd_ld", 4);

        // Drop enable one cycle into the high phase at div=3
        do_reset();
        step(1'b0, 1'b1, 8'd3, 3'b000, "stop", 0);
        step(1'b0, 1'b0, 8'd3, 3'b001, "stop", 1);
        step(1'b1, 1'b0, 8'd3, 3'b110, "stop", 2);
        step(1'b0, 1'b0, 8'd3, 3'b110, "stop", 3);
        step(1'b0, 1'b0, 8'd3, 3'b110, "stop", 4);
        step(1'b0, 1'b0, 8'd3, 3'b110, "stop", 5);
        step(1'b0, 1'b0, 8'd3, 3'b010, "stop", 6);
        step(1'b0, 1'b0, 8'd3, 3'b010, "stop", 7);
        step(1'b0, 1'b0, 8'd3, 3'b010, "stop", 8);
        step(1'b0, 1'b0, 8'd3, 3'b010, "stop", 9);
        step(1'b0, 1'b0, 8'd3, 3'b000, "stop", 10);
        step(1'b0, 1'b0, 8'd3, 3'b000, "stop", 11);
        step(1'b0, 1'b0, 8'd3, 3'b000, "stop", 12);

        // Async reset mid-high at div=3, restart at default period 4
        do_reset();
        step(1'b0, 1'b1, 8'd3, 3'b000, "rst_mid", 0);
        step(1'b0, 1'b0, 8'd3, 3'b001, "rst_mid", 1);
        step(1'b1, 1'b0, 8'd3, 3'b110, "rst_mid", 2);
        step(1'b1, 1'b0, 8'd3, 3'b110, "rst_mid", 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 0, 3'b000);
        @(negedge core_clock);
        @(negedge core_clock);
        check("rst_hold", 0, 3'b000);
        rst_n = 1'b1;
        @(posedge core_clock);
        #1;
        check("rst_restart", 0, 3'b110);
        step(1'b1, 1'b0, 8'd3, 3'b110, "rst_restart", 1);
        step(1'b1, 1'b0, 8'd3, 3'b010, "rst_restart", 2);
        step(1'b1, 1'b0, 8'd3, 3'b010, "rst_restart", 3);
        step(1'b1, 1'b0, 8'd3, 3'b110, "rst_restart", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
